// File: rtl/router_pkg.sv
// Shared definitions for the board-to-board link: word width, word type and
// the link round trip that bounds the receive-side skid headroom.
package router_pkg;

  localparam int LINK_W   = 11;
  localparam int LINK_RTT = 6;

  typedef logic [LINK_W-1:0] link_word_t;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/interboard_input_fifo.sv
// Synchronous show-ahead FIFO. The head word and its valid flag are held in
// registers; the storage array is written and read synchronously, with a
// write-to-head bypass so a word pushed into an empty (or draining) FIFO is
// visible the cycle after it is written.
module interboard_input_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              input_clk,
  input  logic              reset,
  input  logic              push,
  input  logic [LINK_W-1:0] din,
  input  logic              pop,
  output logic [LINK_W-1:0] dout,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  link_word_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW:0]     count_reg, count_next;
  link_word_t      dout_reg;
  logic            valid_reg;
  logic            push_acc;
  logic            pop_acc;

  // Pop only a word that exists; a push into a full FIFO is taken only when
  // the head leaves in the same cycle.
  always_comb begin
    pop_acc     = pop & valid_reg;
    push_acc    = push & ((count_reg != DEPTH_C) | pop_acc);
    wr_ptr_next = wr_ptr_reg + AW'(push_acc);
    rd_ptr_next = rd_ptr_reg + AW'(pop_acc);
    count_next  = count_reg + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop_acc};
  end

  // Storage array: synchronous write, no reset so it maps onto block RAM.
  always_ff @(posedge input_clk) begin
    if (push_acc) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      dout_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      valid_reg  <= (count_next != '0);
      // The next head is either already stored or being written right now.
      if (push_acc && (wr_ptr_reg == rd_ptr_next)) begin
        dout_reg <= din;
      end else begin
        dout_reg <= mem[rd_ptr_next];
      end
    end
  end

  assign dout  = dout_reg;
  assign count = count_reg;
  assign full  = (count_reg == DEPTH_C);
  assign empty = ~valid_reg;

endmodule

// File: rtl/interboard_input.sv
// Receive side of the board-to-board link: two-flop resynchronisation of the
// incoming word/valid pair, FIFO buffering, skid-based flow control back to
// the sender, a sticky overflow flag and an accepted-word counter.
module interboard_input
  import router_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SKID  = 8
) (
  input  logic              input_clk,
  input  logic              reset,
  input  logic              link_valid,
  input  logic [LINK_W-1:0] link_data,
  output logic              read_out,
  output logic              out_valid,
  output logic [LINK_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              clr_overflow,
  output logic              overflow,
  output logic [15:0]       word_count
);

  localparam int AW = $clog2(DEPTH);

  // Parameter sanity, caught at elaboration.
  if (!is_pow2(DEPTH) || DEPTH < 8) begin : g_bad_depth
    $error("interboard_input: DEPTH must be a power of two and at least 8");
  end
  if (SKID < LINK_RTT || SKID >= DEPTH) begin : g_bad_skid
    $error("interboard_input: SKID must cover the link round trip and be below DEPTH");
  end

  // Bit LINK_W carries valid, the rest carry data.
  logic [LINK_W:0] link_bus;
  logic [LINK_W:0] s1_reg;
  logic [LINK_W:0] s2_reg;

  assign link_bus = {link_valid, link_data};

  genvar gi;
  for (gi = 0; gi <= LINK_W; gi++) begin : g_sync
    // Two-flop synchroniser for one link bit; the sender keeps data stable
    // around valid so the bits need no mutual handshake.
    always_ff @(posedge input_clk or negedge reset) begin
      if (!reset) begin
        s1_reg[gi] <= 1'b0;
        s2_reg[gi] <= 1'b0;
      end else begin
        s1_reg[gi] <= link_bus[gi];
        s2_reg[gi] <= s1_reg[gi];
      end
    end
  end

  logic              s2_valid;
  link_word_t        s2_data;
  logic [AW:0]       fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              accept;
  logic              drop;
  logic [AW:0]       count_next;
  logic              read_out_reg;
  logic              overflow_reg;
  logic [15:0]       word_count_reg;

  assign s2_valid = s2_reg[LINK_W];
  assign s2_data  = s2_reg[LINK_W-1:0];

  // Push/pop decisions mirror the FIFO's own acceptance rule so the flags
  // and counters agree with what the FIFO actually stores.
  always_comb begin
    pop        = ~fifo_empty & out_ready;
    accept     = s2_valid & (~fifo_full | pop);
    drop       = s2_valid & ~accept;
    count_next = fifo_count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
  end

  interboard_input_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .input_clk (input_clk),
    .reset     (reset),
    .push      (s2_valid),
    .din       (s2_data),
    .pop       (pop),
    .dout      (out_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Flow control, sticky overflow (set beats clear) and accepted-word count.
  always_ff @(posedge input_clk or negedge reset) begin
    if (!reset) begin
      read_out_reg   <= 1'b0;
      overflow_reg   <= 1'b0;
      word_count_reg <= '0;
    end else begin
      read_out_reg <= ((DEPTH - int'(count_next)) >= SKID);
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clr_overflow) begin
        overflow_reg <= 1'b0;
      end
      word_count_reg <= word_count_reg + 16'(accept);
    end
  end

  assign read_out   = read_out_reg;
  assign out_valid  = ~fifo_empty;
  assign overflow   = overflow_reg;
  assign word_count = word_count_reg;

endmodule

// File: tb/tb_interboard_input.sv
// Self-checking bench for interboard_input. A queue-based model of the
// receive path (two-cycle synchroniser delay, bounded FIFO, flags) supplies
// every expected value.
module tb_interboard_input;

  localparam int DEPTH = 16;
  localparam int SKID  = 8;

  logic        input_clk = 1'b0;
  logic        reset = 1'b0;
  logic        link_valid = 1'b0;
  logic [10:0] link_data = '0;
  logic        read_out;
  logic        out_valid;
  logic [10:0] out_data;
  logic        out_ready = 1'b0;
  logic        clr_overflow = 1'b0;
  logic        overflow;
  logic [15:0] word_count;

  int n_checks = 0;
  int n_pass   = 0;

  interboard_input #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .input_clk    (input_clk),
    .reset        (reset),
    .link_valid   (link_valid),
    .link_data    (link_data),
    .read_out     (read_out),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .clr_overflow (clr_overflow),
    .overflow     (overflow),
    .word_count   (word_count)
  );

  always #5 input_clk = ~input_clk;

  // Reference model state
  logic [10:0] m_q[$];
  logic        m_s1v, m_s2v;
  logic [10:0] m_s1d, m_s2d;
  logic        m_of, m_ro;
  logic [15:0] m_wc;

  task automatic model_reset();
    m_q.delete();
    m_s1v = 0; m_s2v = 0; m_s1d = '0; m_s2d = '0;
    m_of = 0; m_ro = 0; m_wc = '0;
  endtask

  function automatic logic [29:0] expv();
    logic v;
    v = (m_q.size() != 0);
    return {m_ro, v, (v ? m_q[0] : 11'h000), m_of, m_wc};
  endfunction

  function automatic logic [29:0] obs();
    return {read_out, out_valid, (out_valid ? out_data : 11'h000), overflow, word_count};
  endfunction

  // One clock: drive inputs on the falling edge, advance the model at the rising edge.
  task automatic step(input logic lv, input logic [10:0] ld, input logic rdy, input logic clr);
    bit pop, acc;
    @(negedge input_clk);
    link_valid = lv; link_data = ld; out_ready = rdy; clr_overflow = clr;
    @(posedge input_clk);
    pop = (m_q.size() != 0) && rdy;
    acc = m_s2v && ((m_q.size() < DEPTH) || pop);
    if (pop) void'(m_q.pop_front());
    if (acc) begin m_q.push_back(m_s2d); m_wc = m_wc + 16'd1; end
    if (m_s2v && !acc) m_of = 1'b1;
    else if (clr) m_of = 1'b0;
    m_s2v = m_s1v; m_s2d = m_s1d; m_s1v = lv; m_s1d = ld;
    m_ro = ((DEPTH - m_q.size()) >= SKID);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge input_clk);
    #1;
    n_checks++;
    if ({read_out, out_valid, out_data, overflow, word_count} !== 30'h0) begin
      $display("FAIL reset_state: got %b/%b/%h/%b/%h required all zero",
               read_out, out_valid, out_data, overflow, word_count);
    end else n_pass++;
    @(negedge input_clk);
    reset = 1'b1;
    step(0, '0, 1, 0);
    n_checks++;
    if (read_out !== 1'b1) $display("FAIL read_out_after_release: got %b required 1", read_out);
    else n_pass++;
  endtask

  task automatic test_single_word();
    int edges;
    step(1, 11'h5A3, 1, 0);
    edges = 1;
    while (out_valid !== 1'b1 && edges < 10) begin
      step(0, '0, 1, 0);
      edges++;
    end
    n_checks++;
    if (edges !== 3 || out_data !== 11'h5A3)
      $display("FAIL single_latency: got edges=%0d data=%h required edges=3 data=5a3", edges, out_data);
    else n_pass++;
    n_checks++;
    if (obs() !== expv()) $display("FAIL single_model: got %h required %h", obs(), expv());
    else n_pass++;
    step(0, '0, 1, 0);
    n_checks++;
    if (word_count !== 16'd1 || out_valid !== 1'b0)
      $display("FAIL single_count: got wc=%h valid=%b required wc=0001 valid=0", word_count, out_valid);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int fall_at;
    fall_at = -1;
    for (int i = 0; i < 18; i++) begin
      step(i < 16, 11'(i), 0, 0);
      if (read_out === 1'b0 && fall_at < 0) fall_at = m_q.size();
      n_checks++;
      if (obs() !== expv()) $display("FAIL backpressure_cycle%0d: got %h required %h", i, obs(), expv());
      else n_pass++;
    end
    n_checks++;
    if (fall_at !== 9) $display("FAIL read_out_fall: got fall at count %0d required 9", fall_at);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b0 || word_count !== m_wc)
      $display("FAIL backpressure_flags: got of=%b wc=%h required of=0 wc=%h", overflow, word_count, m_wc);
    else n_pass++;
  endtask

  task automatic test_overflow();
    step(1, 11'h7FF, 0, 0);
    repeat (3) step(0, '0, 0, 0);
    n_checks++;
    if (overflow !== 1'b1 || word_count !== m_wc || out_data !== 11'h000)
      $display("FAIL overflow_drop: got of=%b wc=%h head=%h required of=1 wc=%h head=000",
               overflow, word_count, out_data, m_wc);
    else n_pass++;
    step(0, '0, 0, 1);
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL overflow_clear: got %b required 0", overflow);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    step(1, 11'h2B4, 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    n_checks++;
    if (obs() !== expv() || overflow !== 1'b0 || read_out !== 1'b0)
      $display("FAIL full_push_pop: got %h required %h", obs(), expv());
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      step(0, '0, 1, 0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL drain_cycle%0d: got %h required %h", i, obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55), 11'($urandom), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 8));
      n_checks++;
      if (obs() !== expv()) $display("FAIL random_cycle%0d: got %h required %h", i, obs(), expv());
      else n_pass++;
    end
    repeat (20) step(0, '0, 1, 0);
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    while (m_wc != 16'hFFFF && guard < 70000) begin
      step(1, 11'($urandom), 1, 0);
      guard++;
    end
    n_checks++;
    if (word_count !== 16'hFFFF) $display("FAIL wrap_ffff: got %h required ffff", word_count);
    else n_pass++;
    step(1, 11'($urandom), 1, 0);
    n_checks++;
    if (word_count !== 16'h0000) $display("FAIL wrap_zero: got %h required 0000", word_count);
    else n_pass++;
    repeat (4) step(0, '0, 1, 0);
    n_checks++;
    if (obs() !== expv()) $display("FAIL wrap_idle: got %h required %h", obs(), expv());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1, 11'($urandom), 0, 0);
    repeat (3) step(0, '0, 0, 0);
    n_checks++;
    if (out_valid !== 1'b1 || obs() !== expv())
      $display("FAIL pre_reset_queue: got %h required %h", obs(), expv());
    else n_pass++;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({read_out, out_valid, out_data, overflow, word_count} !== 30'h0)
      $display("FAIL async_reset: got %b/%b/%h/%b/%h required all zero",
               read_out, out_valid, out_data, overflow, word_count);
    else n_pass++;
    @(negedge input_clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(0, '0, 1, 0);
      n_checks++;
      if (obs() !== expv() || out_valid !== 1'b0)
        $display("FAIL post_reset_cycle%0d: got %h required %h", i, obs(), expv());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/interboard_input.md
# interboard_input

Receive side of the board-to-board link. It samples the 11-bit word/valid pair driven by the upstream board's link transmitter and resynchronises it into the local clock domain. Words are buffered in a local FIFO, and flow is throttled back to the sender through `read_out` with enough skid headroom to absorb words already in flight. Buffered words are presented to the local router as a valid/ready stream.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in words; power of two, minimum 8.
- `SKID`, 8: free entries required to keep `read_out` high; must be at least the link round trip (6) and less than `DEPTH`.

Ports:
- `input_clk`  input  1: local clock; single clock for the whole block.
- `reset`  input  1: asynchronous, active-low (0 = in reset).
- `link_valid`  input  1: valid from the sending board; asynchronous to `input_clk`.
- `link_data`  input  11: data from the sending board; asynchronous.
- `read_out`  output  1: permission to send, driven to the sending board.
- `out_valid`  output  1: word available to the router.
- `out_data`  output  11: head-of-FIFO word.
- `out_ready`  input  1: router accepts the word.
- `clr_overflow`  input  1: clears `overflow`.
- `overflow`  output  1: sticky flag, a word was dropped.
- `word_count`  output  16: count of accepted words; wraps.

## Operation
- **Synchroniser:** `link_valid` and `link_data` each pass through two flops (`s1`, `s2`). The sender holds data stable for a full cycle around valid, so no per-bit handshake is needed.
- **Push:** when `s2_valid` = 1, the word `s2_data` is pushed.
  - Accepted if `count < DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the word is dropped, `overflow` is set, and `word_count` is not incremented.
- **Pop:** when `out_valid & out_ready`.
- **Simultaneous push and pop:** count is unchanged, and the push is accepted even when the FIFO is full.
- **`read_out`:** registered as `(DEPTH - count_next) >= SKID`. It is recomputed every cycle and has no hysteresis.
- **`overflow`:**
  - Set on a drop.
  - Cleared by `clr_overflow` = 1.
  - If set and clear occur in the same cycle, set wins.
- **`word_count`:** increments by 1 per accepted push, mod 2^16 (0xFFFF -> 0x0000).
- **Pointers:** read and write pointers are `log2(DEPTH)` bits and wrap naturally. `count` is `log2(DEPTH)+1` bits.
- **State machine:** none beyond FIFO occupancy. Behaviour is fully determined by `count`, the push and pop conditions, and the flags.

## Timing
- **Reset values** (asynchronous, immediate while `reset` = 0):
  - `read_out`, `out_valid`, `overflow`, `word_count`, `out_data` = 0.
  - Synchroniser flops = 0; pointers = 0; `count` = 0.
- **After reset release:** `read_out` = 1 after the first rising edge.
- **Latency:** a word sampled into `s1` at edge E0 reaches `s2` at E1. It is written at E2, and `out_valid` = 1 after E2 if the FIFO was empty. Link-to-output latency is 3 edges.
- **Output format:** show-ahead. `out_data` is valid whenever `out_valid` = 1, and both are driven from registers.
- **Router stall:** `out_valid` stays high and `out_data` holds its value while `out_ready` = 0.
- **Throughput:** one push and one pop per cycle, sustained.
- **Reset mid-operation:** FIFO contents are discarded and all outputs go to their reset values asynchronously. `word_count` restarts at 0.

## Structure
- **Shared package `router_pkg`:**
  - `LINK_W = 11`
  - `typedef logic [LINK_W-1:0] link_word_t`
  - `LINK_RTT = 6`, used for the `SKID` lower-bound assertion.
- **Sub-module:** `interboard_input_fifo`, a synchronous show-ahead FIFO.
  - Ports: `push`, `din`, `pop`, `dout`, `count`, `full`, `empty`.
  - The synchroniser, flow control and counters live in the top level.

## Test plan
- **Reset then single word:** release reset; drive `link_valid` = 1 with data 0x5A3 for one cycle and hold `out_ready` = 1. Expect `read_out` = 1 one edge after release, `out_valid` = 1 with `out_data` = 0x5A3 exactly 3 edges after sampling, then `word_count` = 1.
- **Backpressure:** hold `out_ready` = 0 and stream words 0..15 with `DEPTH`=16, `SKID`=8. Expect `read_out` to fall once `count` reaches 9, and all 16 words to be retained in order with `overflow` = 0.
- **Overflow:** with the FIFO full and `out_ready` = 0, push one more word, 0x7FF. Expect the word dropped, `overflow` = 1 and `word_count` unchanged. Then assert `clr_overflow` and expect `overflow` = 0.
- **Full with push and pop:** with the FIFO full, push and pop in the same cycle. Expect the push accepted, `count` to stay 16 and `overflow` = 0.
- **Counter wrap:** preload or stream 65,536 words. Expect `word_count` to go 0xFFFF -> 0x0000.
- **Reset mid-stream:** assert `reset` = 0 with 5 words queued. Expect `out_valid` = 0 and `read_out` = 0 immediately. After release, expect an empty FIFO and no stale words emitted.
